// File: rtl/mul_pkg.sv
// Shared definitions for the iterative RV32M multiply unit.
package mul_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } mul_state_e;

  // Two's-complement magnitude when the operand is negative; 0x80000000 stays as-is.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_neg);
    return is_neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_iter_unit_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module mul_iter_unit_cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  localparam int unsigned W  = 32;
  localparam int unsigned GW = 4;
  localparam int unsigned NG = W / GW;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < NG; k++) begin
      c[k*GW+1] = g[k*GW] | (p[k*GW] & c[k*GW]);
      c[k*GW+2] = g[k*GW+1] | (p[k*GW+1] & g[k*GW])
                | (p[k*GW+1] & p[k*GW] & c[k*GW]);
      c[k*GW+3] = g[k*GW+2] | (p[k*GW+2] & g[k*GW+1])
                | (p[k*GW+2] & p[k*GW+1] & g[k*GW])
                | (p[k*GW+2] & p[k*GW+1] & p[k*GW] & c[k*GW]);
      c[k*GW+4] = g[k*GW+3] | (p[k*GW+3] & g[k*GW+2])
                | (p[k*GW+3] & p[k*GW+2] & g[k*GW+1])
                | (p[k*GW+3] & p[k*GW+2] & p[k*GW+1] & g[k*GW])
                | (p[k*GW+3] & p[k*GW+2] & p[k*GW+1] & p[k*GW] & c[k*GW]);
    end
    sum  = p ^ c[W-1:0];
    cout = c[W];
  end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
module mul_iter_unit
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  mul_state_e state;
  mul_state_e state_nx;

  logic [1:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   m_q;
  logic [2*XLEN-1:0] p_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;

  logic            accept;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] add_sum;
  logic            add_co;
  logic [XLEN:0]   step_sum;
  logic [2*XLEN-1:0] fix_prod;

  mul_iter_unit_cla u_cla (
    .a    (p_q[2*XLEN-1:XLEN]),
    .b    (m_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state; flush overrides everything except reset.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        accept   = 1'b1;
        state_nx = PREP;
      end
      PREP: state_nx = CALC;
      CALC: if (cnt_q == CNT_W'(ITER - 1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
      accept   = 1'b0;
    end
  end

  always_comb begin
    a_neg    = ((op_q == MUL_OP_MULH) || (op_q == MUL_OP_MULHSU)) && a_q[XLEN-1];
    b_neg    = (op_q == MUL_OP_MULH) && b_q[XLEN-1];
    step_sum = p_q[0] ? {add_co, add_sum} : {1'b0, p_q[2*XLEN-1:XLEN]};
    fix_prod = neg_q ? (~p_q + (2*XLEN)'(1)) : p_q;
  end

  // Operand capture and shift-add datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      out_result <= '0;
    end else begin
      if (accept) begin
        op_q <= in_op;
        a_q  <= in_a;
        b_q  <= in_b;
      end
      case (state)
        PREP: begin
          m_q   <= mag(a_q, a_neg);
          p_q   <= {XLEN'(0), mag(b_q, b_neg)};
          cnt_q <= '0;
          neg_q <= a_neg ^ b_neg;
        end
        CALC: begin
          p_q   <= {step_sum, p_q[XLEN-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIX: if (!flush) begin
          p_q        <= fix_prod;
          out_result <= (op_q == MUL_OP_MUL) ? fix_prod[XLEN-1:0] : fix_prod[2*XLEN-1:XLEN];
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
      busy      <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Scoreboard bench for mul_iter_unit: directed cases, random ops, backpressure, flush, reset.
module tb_mul_iter_unit;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  always #5 clk = ~clk;

  mul_iter_unit dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  // Reference via sign/zero-extension and a 64-bit modular product.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == MUL_OP_MULH || op == MUL_OP_MULHSU) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op == MUL_OP_MULH) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_op    = 2'($urandom_range(0, 3));
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b result=%h required 1 0 0 00000000",
               in_ready, out_valid, busy, out_result);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    logic [31:0] e;
    exp_q.push_back(v.e);
    issue(v.op, v.a, v.b);
    wait_valid(lat);
    checks++;
    if (lat !== 34) begin
      failures++;
      $display("FAIL %s latency: got %0d required 34", name, lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (out_result !== e) begin
      failures++;
      $display("FAIL %s result: got %h required %h", name, out_result, e);
    end
    take();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s release: in_ready=%b out_valid=%b required 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    vec_t v[6];
    v[0] = '{MUL_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    v[1] = '{MUL_OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    v[2] = '{MUL_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
    v[3] = '{MUL_OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    v[4] = '{MUL_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    v[5] = '{MUL_OP_MULH,   32'h00000000, 32'h80000000, 32'h00000000};
    for (int i = 0; i < 6; i++) run_vec(v[i], $sformatf("directed%0d", i));
  endtask

  task automatic test_back_to_back();
    vec_t v;
    for (int i = 0; i < 8; i++) begin
      v.op = 2'(i % 4);
      v.a  = (i == 6) ? 32'h80000000 : $urandom;
      v.b  = (i == 7) ? 32'h80000000 : $urandom;
      v.e  = model(v.op, v.a, v.b);
      run_vec(v, $sformatf("random%0d_op%0d", i, v.op));
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] r0;
    vec_t v;
    exp_q.push_back(32'hFFFFFFFE);
    issue(MUL_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(lat);
    r0 = out_result;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_result !== r0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold%0d: out_valid=%b result=%h in_ready=%b required 1 %h 0",
                 i, out_valid, out_result, in_ready, r0);
      end
    end
    r0 = exp_q.pop_front();
    checks++;
    if (out_result !== r0) begin
      failures++;
      $display("FAIL hold_result: got %h required %h", out_result, r0);
    end
    take();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: in_ready=%b required 1", in_ready);
    end
    v = '{MUL_OP_MUL, 32'd3, 32'd5, 32'h0000000F};
    run_vec(v, "after_hold");
  endtask

  task automatic test_flush();
    int lat;
    logic seen;
    vec_t v;
    issue(MUL_OP_MULHU, 32'h12345678, 32'h9ABCDEF0);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_state: in_ready=%b busy=%b out_valid=%b required 1 0 0", in_ready, busy, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_discard: out_valid rose after flush");
    end
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_idle: busy=%b in_ready=%b required 0 1", busy, in_ready);
    end
    v = '{MUL_OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001};
    run_vec(v, "after_flush");
  endtask

  task automatic test_rst_in_fix();
    int lat;
    logic [31:0] e;
    issue(MUL_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (33) tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_op    = MUL_OP_MUL;
    in_a     = 32'd3;
    in_b     = 32'd5;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0) begin
      failures++;
      $display("FAIL rst_fix: in_ready=%b out_valid=%b busy=%b result=%h required 1 0 0 00000000",
               in_ready, out_valid, busy, out_result);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_hold: busy=%b required 0", busy);
    end
    rst = 1'b0;
    exp_q.push_back(32'h0000000F);
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_accept: busy=%b required 1", busy);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 34) begin
      failures++;
      $display("FAIL rst_accept latency: got %0d required 34", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (out_result !== e) begin
      failures++;
      $display("FAIL rst_accept result: got %h required %h", out_result, e);
    end
    take();
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_a      = 32'h0;
    in_b      = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_rst_in_fix();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
